// File: rtl/lexington_pkg.sv
// Shared lexington definitions: machine-timer register offsets, control layout and reset values.
package lexington;
  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

  localparam logic [4:0] MTIMER_MTIME_LO_OFFSET    = 5'h00;
  localparam logic [4:0] MTIMER_MTIME_HI_OFFSET    = 5'h04;
  localparam logic [4:0] MTIMER_MTIMECMP_LO_OFFSET = 5'h08;
  localparam logic [4:0] MTIMER_MTIMECMP_HI_OFFSET = 5'h0C;
  localparam logic [4:0] MTIMER_CTRL_OFFSET        = 5'h10;

  typedef struct packed {
    logic [7:0] prescale;
    logic       en;
  } mtimer_ctrl_t;

  localparam mtimer_ctrl_t MTIMER_CTRL_RESET = '{prescale: 8'h00, en: 1'b1};
  localparam logic [63:0]  MTIMER_CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return res;
  endfunction

  function automatic logic [31:0] ctrl_word(input mtimer_ctrl_t c);
    return {16'h0000, c.prescale, 7'h00, c.en};
  endfunction

  function automatic logic addr_ok(input logic [4:0] a);
    return (a[1:0] == 2'b00) && (a <= MTIMER_CTRL_OFFSET);
  endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle, 32-bit data, with manager/subordinate views and response codes.
interface axi4_lite #(parameter int ADDR_WIDTH = lexington::DEFAULT_AXI_ADDR_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport manager (
    output araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport subordinate (
    input  araddr, arprot, arvalid, rready, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_lite_mtimer_core.sv
// Machine timer datapath: mtime/mtimecmp/CTRL, tick generation, compare and mtip register.
// Optional prescaler enabled by LEXINGTON_MTIMER_PRESCALE_EN.
module mtimer_core
  import lexington::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         we_mtime_lo,
  input  logic         we_mtime_hi,
  input  logic         we_cmp_lo,
  input  logic         we_cmp_hi,
  input  logic         we_ctrl,
  input  logic [3:0]   wstrb,
  input  logic [31:0]  wdata,
  output logic [63:0]  mtime,
  output logic [63:0]  mtimecmp,
  output mtimer_ctrl_t ctrl,
  output logic         mtip
);
  logic        tick;
  logic [31:0] ctrl_wr;

  assign ctrl_wr = apply_wstrb(ctrl_word(ctrl), wdata, wstrb);

`ifdef LEXINGTON_MTIMER_PRESCALE_EN
  logic [7:0] psc_cnt;
  logic       unused_ctrl_bits;

  assign unused_ctrl_bits = ^{ctrl_wr[31:16], ctrl_wr[7:1]};
  assign tick = ctrl.en && (psc_cnt == ctrl.prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            psc_cnt <= 8'h00;
    else if (we_ctrl || !ctrl.en || tick) psc_cnt <= 8'h00;
    else                                psc_cnt <= psc_cnt + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ctrl <= MTIMER_CTRL_RESET;
    else if (we_ctrl) ctrl <= '{prescale: ctrl_wr[15:8], en: ctrl_wr[0]};
  end
`else
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^ctrl_wr[31:1];
  assign tick = ctrl.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ctrl <= MTIMER_CTRL_RESET;
    else if (we_ctrl) ctrl <= '{prescale: 8'h00, en: ctrl_wr[0]};
  end
`endif

  // A bus write to either half suppresses the tick for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtime <= 64'h0;
    else if (we_mtime_lo || we_mtime_hi)
      mtime <= {we_mtime_hi ? apply_wstrb(mtime[63:32], wdata, wstrb) : mtime[63:32],
                we_mtime_lo ? apply_wstrb(mtime[31:0],  wdata, wstrb) : mtime[31:0]};
    else if (tick) mtime <= mtime + 64'h1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtimecmp <= MTIMER_CMP_RESET;
    else if (we_cmp_lo || we_cmp_hi)
      mtimecmp <= {we_cmp_hi ? apply_wstrb(mtimecmp[63:32], wdata, wstrb) : mtimecmp[63:32],
                   we_cmp_lo ? apply_wstrb(mtimecmp[31:0],  wdata, wstrb) : mtimecmp[31:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtip <= 1'b0;
    else     mtip <= (mtime >= mtimecmp);
  end
endmodule

// File: rtl/axi4_lite_mtimer.sv
// AXI4-Lite front end of the RISC-V machine timer: read/write FSMs, decode, hi_shadow.
// Prescaler option: LEXINGTON_MTIMER_PRESCALE_EN (see mtimer_core).
module axi4_lite_mtimer
  import lexington::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  axi4_lite.subordinate axi_s,
  output logic         mtip
);
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_AW_DONE, WR_W_DONE, WR_RESP} wr_state_t;

  rd_state_t    rd_state, rd_next;
  wr_state_t    wr_state, wr_next;
  logic [63:0]  mtime, mtimecmp;
  mtimer_ctrl_t ctrl;
  logic [31:0]  hi_shadow, rd_mux;
  logic [4:0]   rd_addr, aw_q, wr_addr;
  logic [31:0]  w_data_q, wr_data;
  logic [3:0]   w_strb_q, wr_strb;
  logic         ar_hs, aw_hs, w_hs, commit;
  logic         unused_bits;

  assign unused_bits = ^{axi_s.araddr[ADDR_WIDTH-1:5], axi_s.awaddr[ADDR_WIDTH-1:5],
                         axi_s.arprot, axi_s.awprot};

  assign axi_s.arready = !rst && (rd_state == RD_IDLE);
  assign axi_s.rvalid  = (rd_state == RD_RESP);
  assign axi_s.awready = !rst && (wr_state == WR_IDLE || wr_state == WR_W_DONE);
  assign axi_s.wready  = !rst && (wr_state == WR_IDLE || wr_state == WR_AW_DONE);
  assign axi_s.bvalid  = (wr_state == WR_RESP);

  assign ar_hs   = axi_s.arvalid && axi_s.arready;
  assign aw_hs   = axi_s.awvalid && axi_s.awready;
  assign w_hs    = axi_s.wvalid  && axi_s.wready;
  assign rd_addr = axi_s.araddr[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (axi_s.arvalid) rd_next = RD_RESP;
      RD_RESP: if (axi_s.rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Invalid offsets fall through to zero, which is also the SLVERR data.
  always_comb begin
    rd_mux = 32'h0;
    case (rd_addr)
      MTIMER_MTIME_LO_OFFSET:    rd_mux = mtime[31:0];
      MTIMER_MTIME_HI_OFFSET:    rd_mux = hi_shadow;
      MTIMER_MTIMECMP_LO_OFFSET: rd_mux = mtimecmp[31:0];
      MTIMER_MTIMECMP_HI_OFFSET: rd_mux = mtimecmp[63:32];
      MTIMER_CTRL_OFFSET:        rd_mux = ctrl_word(ctrl);
      default:                   rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_s.rdata <= 32'h0;
      axi_s.rresp <= axi_s.RESP_OKAY;
      hi_shadow   <= 32'h0;
    end else if (ar_hs) begin
      axi_s.rdata <= rd_mux;
      axi_s.rresp <= addr_ok(rd_addr) ? axi_s.RESP_OKAY : axi_s.RESP_SLVERR;
      if (rd_addr == MTIMER_MTIME_LO_OFFSET) hi_shadow <= mtime[63:32];
    end
  end

  // The later channel's payload is taken live so the commit lands on its handshake edge.
  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    wr_addr = axi_s.awaddr[4:0];
    wr_data = axi_s.wdata;
    wr_strb = axi_s.wstrb;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end else if (aw_hs) wr_next = WR_AW_DONE;
        else if (w_hs)      wr_next = WR_W_DONE;
      end
      WR_AW_DONE: begin
        wr_addr = aw_q;
        if (w_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_W_DONE: begin
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        if (aw_hs) begin
          commit  = 1'b1;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: if (axi_s.bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_q        <= 5'h0;
      w_data_q    <= 32'h0;
      w_strb_q    <= 4'h0;
      axi_s.bresp <= axi_s.RESP_OKAY;
    end else begin
      if (aw_hs) aw_q <= axi_s.awaddr[4:0];
      if (w_hs) begin
        w_data_q <= axi_s.wdata;
        w_strb_q <= axi_s.wstrb;
      end
      if (commit) axi_s.bresp <= addr_ok(wr_addr) ? axi_s.RESP_OKAY : axi_s.RESP_SLVERR;
    end
  end

  mtimer_core u_core (
    .clk        (clk),
    .rst        (rst),
    .we_mtime_lo(commit && wr_addr == MTIMER_MTIME_LO_OFFSET),
    .we_mtime_hi(commit && wr_addr == MTIMER_MTIME_HI_OFFSET),
    .we_cmp_lo  (commit && wr_addr == MTIMER_MTIMECMP_LO_OFFSET),
    .we_cmp_hi  (commit && wr_addr == MTIMER_MTIMECMP_HI_OFFSET),
    .we_ctrl    (commit && wr_addr == MTIMER_CTRL_OFFSET),
    .wstrb      (wr_strb),
    .wdata      (wr_data),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .ctrl       (ctrl),
    .mtip       (mtip)
  );
endmodule

// File: tb/tb_axi4_lite_mtimer.sv
// Directed self-checking bench for axi4_lite_mtimer.
module tb_axi4_lite_mtimer;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mtip;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rdat;
  logic [1:0]  rrsp;
  int   n;

  always #5 clk = ~clk;

  axi4_lite #(.ADDR_WIDTH(32)) axi_if ();

  axi4_lite_mtimer #(.ADDR_WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .axi_s(axi_if),
    .mtip (mtip)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rvalid is first due.
  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int k = 0;
    axi_if.araddr  = a;
    axi_if.arvalid = 1'b1;
    axi_if.rready  = 1'b1;
    while (!axi_if.arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rd_arready", axi_if.arready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    axi_if.arvalid = 1'b0;
    check("rd_rvalid", axi_if.rvalid, 1'b1);
    d = axi_if.rdata;
    r = axi_if.rresp;
  endtask

  // Called at a negedge; returns at the negedge right after the commit edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] r);
    int k = 0;
    axi_if.awaddr  = a;
    axi_if.wdata   = d;
    axi_if.wstrb   = s;
    axi_if.awvalid = 1'b1;
    axi_if.wvalid  = 1'b1;
    axi_if.bready  = 1'b1;
    while (!(axi_if.awready && axi_if.wready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wr_ready", axi_if.awready && axi_if.wready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    axi_if.awvalid = 1'b0;
    axi_if.wvalid  = 1'b0;
    check("wr_bvalid", axi_if.bvalid, 1'b1);
    r = axi_if.bresp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi_if.araddr = '0; axi_if.arprot = '0; axi_if.arvalid = 1'b0; axi_if.rready = 1'b1;
    axi_if.awaddr = '0; axi_if.awprot = '0; axi_if.awvalid = 1'b0;
    axi_if.wdata  = '0; axi_if.wstrb  = '0; axi_if.wvalid  = 1'b0; axi_if.bready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", axi_if.arready, 1'b0);
    check("rst_awready", axi_if.awready, 1'b0);
    check("rst_wready",  axi_if.wready,  1'b0);
    check("rst_rvalid",  axi_if.rvalid,  1'b0);
    check("rst_bvalid",  axi_if.bvalid,  1'b0);
    check("rst_rdata",   axi_if.rdata,   32'h0);
    check("rst_rresp",   axi_if.rresp,   OKAY);
    check("rst_bresp",   axi_if.bresp,   OKAY);
    check("rst_mtip",    mtip,           1'b0);
    check("rst_mtime",   dut.u_core.mtime, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    check("rvalid_pre", axi_if.rvalid, 1'b0);
    rd(32'h10, rdat, rrsp);
    check("ctrl_reset", rdat, 32'h0000_0001);
    check("ctrl_resp",  rrsp, OKAY);
    rd(32'h0C, rdat, rrsp);
    check("cmphi_reset", rdat, 32'hFFFF_FFFF);
    check("mtip_reset",  mtip, 1'b0);
    rd(32'h08, rdat, rrsp);
    check("cmplo_reset", rdat, 32'hFFFF_FFFF);

    // 64-bit wrap
    wr(32'h10, 32'h0, 4'hF, rrsp);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, rrsp);
    wr(32'h00, 32'hFFFF_FFFE, 4'hF, rrsp);
    rd(32'h00, rdat, rrsp);
    check("mtime_lo_rd", rdat, 32'hFFFF_FFFE);
    rd(32'h04, rdat, rrsp);
    check("mtime_hi_shadow", rdat, 32'hFFFF_FFFF);
    @(negedge clk);
    wr(32'h10, 32'h1, 4'hF, rrsp);
    check("wrap_t0", dut.u_core.mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check("wrap_t1", dut.u_core.mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_t2", dut.u_core.mtime, 64'h0);
    @(negedge clk);
    check("wrap_t3", dut.u_core.mtime, 64'h1);

    // mtip rise/fall timing
    wr(32'h10, 32'h0, 4'hF, rrsp);
    wr(32'h04, 32'h0, 4'hF, rrsp);
    wr(32'h00, 32'd95, 4'hF, rrsp);
    wr(32'h0C, 32'h0, 4'hF, rrsp);
    wr(32'h08, 32'd100, 4'hF, rrsp);
    wr(32'h10, 32'h1, 4'hF, rrsp);
    check("mtip_below", mtip, 1'b0);
    n = 0;
    while (dut.u_core.mtime != 64'd100 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mtime_reach100", dut.u_core.mtime, 64'd100);
    check("mtip_lag0", mtip, 1'b0);
    @(negedge clk);
    check("mtip_rise", mtip, 1'b1);
    wr(32'h0C, 32'hFFFF_FFFF, 4'hF, rrsp);
    check("mtip_hold", mtip, 1'b1);
    @(negedge clk);
    check("mtip_fall", mtip, 1'b0);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, rrsp);
    @(negedge clk);

    // AW three cycles ahead of W, bready held low
    axi_if.bready  = 1'b0;
    axi_if.awaddr  = 32'h08;
    axi_if.awvalid = 1'b1;
    check("split_awready", axi_if.awready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    axi_if.awvalid = 1'b0;
    check("split_aw_done_awready", axi_if.awready, 1'b0);
    check("split_aw_done_wready",  axi_if.wready,  1'b1);
    check("split_bvalid_pre",      axi_if.bvalid,  1'b0);
    @(negedge clk);
    @(negedge clk);
    axi_if.wdata  = 32'h1122_3344;
    axi_if.wstrb  = 4'hF;
    axi_if.wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.wvalid = 1'b0;
    check("split_bvalid", axi_if.bvalid, 1'b1);
    check("split_bresp",  axi_if.bresp,  OKAY);
    check("split_cmp_lo", dut.u_core.mtimecmp[31:0], 32'h1122_3344);
    repeat (3) begin
      @(negedge clk);
      check("split_bvalid_hold", axi_if.bvalid, 1'b1);
    end
    axi_if.bready = 1'b1;
    @(negedge clk);
    check("split_bvalid_drop", axi_if.bvalid, 1'b0);

    wr(32'h08, 32'h0000_AB00, 4'b0010, rrsp);
    rd(32'h08, rdat, rrsp);
    check("strb_merge", rdat, 32'h1122_AB44);

    // error responses
    rd(32'h14, rdat, rrsp);
    check("rd14_resp", rrsp, SLVERR);
    check("rd14_data", rdat, 32'h0);
    rd(32'h02, rdat, rrsp);
    check("rd02_resp", rrsp, SLVERR);
    check("rd02_data", rdat, 32'h0);
    wr(32'h14, 32'hFFFF_FFFF, 4'hF, rrsp);
    check("wr14_resp", rrsp, SLVERR);
    rd(32'h08, rdat, rrsp);
    check("wr14_cmplo", rdat, 32'h1122_AB44);
    rd(32'h0C, rdat, rrsp);
    check("wr14_cmphi", rdat, 32'hFFFF_FFFF);
    wr(32'h08, 32'hDEAD_BEEF, 4'h0, rrsp);
    check("strb0_resp", rrsp, OKAY);
    rd(32'h08, rdat, rrsp);
    check("strb0_nochange", rdat, 32'h1122_AB44);

    // CTRL reserved bits and prescale
    wr(32'h10, 32'hFFFF_FF00, 4'hF, rrsp);
    rd(32'h10, rdat, rrsp);
`ifdef LEXINGTON_MTIMER_PRESCALE_EN
    check("ctrl_reserved", rdat, 32'h0000_FF00);
`else
    check("ctrl_reserved", rdat, 32'h0000_0000);
`endif
    @(negedge clk);
    wr(32'h04, 32'h0, 4'hF, rrsp);
    wr(32'h00, 32'h1000, 4'hF, rrsp);
    wr(32'h10, 32'h0000_0301, 4'hF, rrsp);
    check("psc_t0", dut.u_core.mtime, 64'h1000);
    repeat (4) @(negedge clk);
`ifdef LEXINGTON_MTIMER_PRESCALE_EN
    check("psc_t4", dut.u_core.mtime, 64'h1001);
    repeat (4) @(negedge clk);
    check("psc_t8", dut.u_core.mtime, 64'h1002);
`else
    check("psc_t4", dut.u_core.mtime, 64'h1004);
`endif
    rd(32'h10, rdat, rrsp);
`ifdef LEXINGTON_MTIMER_PRESCALE_EN
    check("ctrl_301", rdat, 32'h0000_0301);
`else
    check("ctrl_301", rdat, 32'h0000_0001);
`endif
    @(negedge clk);

    // reset during an outstanding read
    axi_if.rready  = 1'b0;
    axi_if.araddr  = 32'h00;
    axi_if.arvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axi_if.arvalid = 1'b0;
    check("midrd_rvalid", axi_if.rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("midrd_rvalid_rst", axi_if.rvalid, 1'b0);
    check("midrd_mtime_rst",  dut.u_core.mtime, 64'h0);
    check("midrd_mtip_rst",   mtip, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    axi_if.rready = 1'b1;
    @(negedge clk);
    rd(32'h10, rdat, rrsp);
    check("post_rst_ctrl", rdat, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
